// File: rtl/game_msg_sequencer.sv
// game_msg_sequencer: queues outgoing game-control messages and emits them one
// at a time over a ctrl_en/ctrl_ack handshake with timeout and bounded resend.
// It also tracks whose turn it is and only transmits on this board's turn.
// STATE_RST_GAME messages are the exception and go out on any turn.
module game_msg_sequencer #(
   parameter int PLAYER      = 0,
   parameter int NUM_PLAYERS = 2,
   parameter int DEPTH       = 8,
   parameter int BX_W        = 5,
   parameter int TIMEOUT     = 1000,
   parameter int MAX_RETRY   = 3
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           interboard_rst,
   input  logic                           push,
   input  logic [3:0]                     push_msg_type,
   input  logic [BX_W-1:0]                push_block_x,
   input  logic [2:0]                     push_block_y,
   input  logic [5:0]                     push_card,
   input  logic [2:0]                     push_sel_len,
   input  logic                           push_move_dir,
   output logic                           full,
   output logic [$clog2(DEPTH):0]         count,
   output logic                           overflow,
   output logic                           ctrl_en,
   output logic [3:0]                     ctrl_msg_type,
   output logic [BX_W-1:0]                ctrl_block_x,
   output logic [2:0]                     ctrl_block_y,
   output logic [5:0]                     ctrl_card,
   output logic [2:0]                     ctrl_sel_len,
   output logic                           ctrl_move_dir,
   input  logic                           ctrl_ack,
   input  logic                           rx_turn,
   input  logic                           rx_rst_game,
   output logic [$clog2(NUM_PLAYERS)-1:0] turn_player,
   output logic                           transmit,
   output logic                           busy,
   output logic                           error
);

   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int TW  = $clog2(NUM_PLAYERS);
   localparam int TOW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int RW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [3:0] MSG_TURN     = 4'd6;
   localparam logic [3:0] MSG_RST_GAME = 4'd8;

   typedef struct packed {
      logic [3:0]      msg_type;
      logic [BX_W-1:0] block_x;
      logic [2:0]      block_y;
      logic [5:0]      card;
      logic [2:0]      sel_len;
      logic            move_dir;
   } msg_t;

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_ACK, S_ERR} state_t;

   msg_t            mem [DEPTH];
   msg_t            push_data;
   msg_t            held;
   logic [AW-1:0]   rd_ptr, wr_ptr;
   logic [CW-1:0]   cnt;
   logic            overflow_q;
   state_t          state, state_nxt;
   logic            pop, push_ok, ack_take, retry_inc;
   logic [TOW-1:0]  timer;
   logic [RW-1:0]   retries;
   logic [TW-1:0]   turn, turn_inc;
   logic            turn_reset, turn_advance;

   assign push_data = {push_msg_type, push_block_x, push_block_y,
                       push_card, push_sel_len, push_move_dir};

   // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
   assign push_ok  = push && ((cnt != CW'(DEPTH)) || pop);
   assign full     = (cnt == CW'(DEPTH));
   assign count    = cnt;
   assign overflow = overflow_q;

   assign transmit = (turn == TW'(PLAYER));
   assign turn_player = turn;
   assign turn_inc = (turn == TW'(NUM_PLAYERS - 1)) ? '0 : turn + TW'(1);

   assign ctrl_en       = (state == S_SEND);
   assign busy          = (state != S_IDLE);
   assign error         = (state == S_ERR);
   assign ctrl_msg_type = held.msg_type;
   assign ctrl_block_x  = held.block_x;
   assign ctrl_block_y  = held.block_y;
   assign ctrl_card     = held.card;
   assign ctrl_sel_len  = held.sel_len;
   assign ctrl_move_dir = held.move_dir;

   // Next-state logic and one-cycle control strobes of the send FSM.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_nxt = state;
      pop       = 1'b0;
      ack_take  = 1'b0;
      retry_inc = 1'b0;
      case (state)
         S_IDLE: begin
            if ((cnt != '0) && (transmit || (mem[rd_ptr].msg_type == MSG_RST_GAME))) begin
               pop       = 1'b1;
               state_nxt = S_SEND;
            end
         end
         S_SEND: state_nxt = S_WAIT_ACK;
         S_WAIT_ACK: begin
            if (ctrl_ack) begin
               ack_take  = 1'b1;
               state_nxt = S_IDLE;
            end else if (timer == '0) begin
               if (retries == RW'(MAX_RETRY)) begin
                  state_nxt = S_ERR;
               end else begin
                  retry_inc = 1'b1;
                  state_nxt = S_SEND;
               end
            end
         end
         S_ERR:   state_nxt = S_ERR;
         default: state_nxt = S_IDLE;
      endcase
   end

   // FSM state register; ERR is left only through a reset.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst) begin
         state <= S_IDLE;
      end else if (interboard_rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         cnt        <= '0;
         overflow_q <= 1'b0;
      end else if (interboard_rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         cnt        <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         if (push_ok && !pop)      cnt <= cnt + CW'(1);
         else if (!push_ok && pop) cnt <= cnt - CW'(1);
         if (push && !push_ok) overflow_q <= 1'b1;
      end
   end

   // FIFO storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      // NOTE: the message array has no reset; emptying the FIFO is done by the pointers alone.
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   // Held message, resend timer and retry counter for the message in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         held    <= '0;
         timer   <= '0;
         retries <= '0;
      end else if (interboard_rst) begin
         held    <= '0;
         timer   <= '0;
         retries <= '0;
      end else begin
         if (pop) begin
            held    <= mem[rd_ptr];
            retries <= '0;
         end else if (retry_inc) begin
            retries <= retries + RW'(1);
         end
         if (state == S_SEND) begin
            timer <= TOW'(TIMEOUT - 1);
         end else if ((state == S_WAIT_ACK) && (timer != '0)) begin
            timer <= timer - TOW'(1);
         end
      end
   end

   // Turn tracking: game reset beats an advance; local and remote advances merge into one step.
   assign turn_reset   = rx_rst_game || (ack_take && (held.msg_type == MSG_RST_GAME));
   assign turn_advance = rx_turn || (ack_take && (held.msg_type == MSG_TURN));

   // Turn register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         turn <= '0;
      end else if (interboard_rst) begin
         turn <= '0;
      end else if (turn_reset) begin
         turn <= '0;
      end else if (turn_advance) begin
         turn <= turn_inc;
      end
   end

endmodule

// File: tb/tb_game_msg_sequencer.sv
// Testbench for game_msg_sequencer: turn-tracking vector table, directed
// sequences for latency, ordering, overflow, resend/error and async reset,
// then randomized traffic scored against a queue-based transaction model.
module tb_game_msg_sequencer;

   localparam int PLAYER      = 1;
   localparam int NUM_PLAYERS = 3;
   localparam int DEPTH       = 8;
   localparam int BX_W        = 5;
   localparam int TIMEOUT     = 10;
   localparam int MAX_RETRY   = 3;

   typedef struct packed {
      logic [3:0] t;
      logic [4:0] x;
      logic [2:0] y;
      logic [5:0] card;
      logic [2:0] len;
      logic       dir;
   } msg_t;

   typedef struct {
      logic rx_t;
      logic rx_r;
      int   exp_turn;
      logic exp_tx;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       interboard_rst = 1'b0;
   logic       push = 1'b0;
   logic [3:0] push_msg_type = '0;
   logic [4:0] push_block_x = '0;
   logic [2:0] push_block_y = '0;
   logic [5:0] push_card = '0;
   logic [2:0] push_sel_len = '0;
   logic       push_move_dir = 1'b0;
   logic       full;
   logic [3:0] count;
   logic       overflow;
   logic       ctrl_en;
   logic [3:0] ctrl_msg_type;
   logic [4:0] ctrl_block_x;
   logic [2:0] ctrl_block_y;
   logic [5:0] ctrl_card;
   logic [2:0] ctrl_sel_len;
   logic       ctrl_move_dir;
   logic       ctrl_ack = 1'b0;
   logic       rx_turn = 1'b0;
   logic       rx_rst_game = 1'b0;
   logic [1:0] turn_player;
   logic       transmit;
   logic       busy;
   logic       error;

   int n_checks = 0;
   int n_errors = 0;

   game_msg_sequencer #(
      .PLAYER(PLAYER), .NUM_PLAYERS(NUM_PLAYERS), .DEPTH(DEPTH),
      .BX_W(BX_W), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)
   ) dut (
      .clk(clk), .rst(rst), .interboard_rst(interboard_rst),
      .push(push), .push_msg_type(push_msg_type), .push_block_x(push_block_x),
      .push_block_y(push_block_y), .push_card(push_card),
      .push_sel_len(push_sel_len), .push_move_dir(push_move_dir),
      .full(full), .count(count), .overflow(overflow),
      .ctrl_en(ctrl_en), .ctrl_msg_type(ctrl_msg_type), .ctrl_block_x(ctrl_block_x),
      .ctrl_block_y(ctrl_block_y), .ctrl_card(ctrl_card), .ctrl_sel_len(ctrl_sel_len),
      .ctrl_move_dir(ctrl_move_dir), .ctrl_ack(ctrl_ack),
      .rx_turn(rx_turn), .rx_rst_game(rx_rst_game),
      .turn_player(turn_player), .transmit(transmit), .busy(busy), .error(error)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance to the next falling edge and drop all one-cycle pulses.
   task automatic tick();
      @(negedge clk);
      push = 1'b0;
      ctrl_ack = 1'b0;
      rx_turn = 1'b0;
      rx_rst_game = 1'b0;
      interboard_rst = 1'b0;
   endtask

   task automatic push_msg(input msg_t m);
      push = 1'b1;
      push_msg_type = m.t;
      push_block_x = m.x;
      push_block_y = m.y;
      push_card = m.card;
      push_sel_len = m.len;
      push_move_dir = m.dir;
   endtask

   function automatic msg_t out_msg();
      return {ctrl_msg_type, ctrl_block_x, ctrl_block_y, ctrl_card, ctrl_sel_len, ctrl_move_dir};
   endfunction

   function automatic msg_t rand_msg();
      msg_t m;
      m.t = 4'($urandom_range(0, 9));
      m.x = 5'($urandom);
      m.y = 3'($urandom);
      m.card = 6'($urandom);
      m.len = 3'($urandom);
      m.dir = 1'($urandom);
      return m;
   endfunction

   function automatic msg_t mk(input int t, input int x, input int y, input int card);
      msg_t m;
      m.t = 4'(t);
      m.x = 5'(x);
      m.y = 3'(y);
      m.card = 6'(card);
      m.len = 3'(t + 1);
      m.dir = 1'(x);
      return m;
   endfunction

   task automatic wait_en(input string name, input int budget);
      int n;
      n = 0;
      while (ctrl_en !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check(name, ctrl_en, 1);
   endtask

   // From the SEND cycle: move into WAIT_ACK, acknowledge, land back in IDLE.
   task automatic do_ack();
      tick();
      ctrl_ack = 1'b1;
      tick();
   endtask

   vec_t vecs[8];
   msg_t dmsg[9];
   msg_t m;
   int   times[8];
   int   np;
   bit   seen;

   msg_t q[$];
   msg_t cur;
   bit   outstanding, ack_now, rxt, rxr;
   int   ack_in, turn_m, prev_turn;

   initial begin
      vecs[0] = '{1'b1, 1'b0, 1, 1'b1};
      vecs[1] = '{1'b1, 1'b0, 2, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 0, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 0, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 1, 1'b1};
      vecs[5] = '{1'b0, 1'b1, 0, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 1, 1'b1};
      vecs[7] = '{1'b0, 1'b0, 1, 1'b1};

      // Reset state.
      repeat (3) @(negedge clk);
      rst = 1'b1;
      tick();
      check("rst_count", count, 0);
      check("rst_full", full, 0);
      check("rst_overflow", overflow, 0);
      check("rst_ctrl_en", ctrl_en, 0);
      check("rst_fields", out_msg(), 0);
      check("rst_turn", turn_player, 0);
      check("rst_transmit", transmit, 0);
      check("rst_busy", busy, 0);
      check("rst_error", error, 0);

      // Turn-tracking vectors.
      for (int i = 0; i < 8; i++) begin
         rx_turn = vecs[i].rx_t;
         rx_rst_game = vecs[i].rx_r;
         tick();
         check($sformatf("vec%0d_turn", i), turn_player, vecs[i].exp_turn);
         check($sformatf("vec%0d_transmit", i), transmit, vecs[i].exp_tx);
      end

      // Single message latency and fields; a plain message does not move the turn.
      m = mk(1, 3, 2, 17);
      push_msg(m);
      tick();
      check("lat_cycle1_no_en", ctrl_en, 0);
      tick();
      check("lat_cycle2_en", ctrl_en, 1);
      check("lat_fields", out_msg(), m);
      do_ack();
      check("lat_idle_after_ack", busy, 0);
      check("lat_turn_kept", turn_player, 1);

      // Gated by the turn, then sent in order once the turn arrives.
      rx_turn = 1'b1;
      tick();
      rx_turn = 1'b1;
      tick();
      dmsg[0] = mk(2, 7, 1, 33);
      dmsg[1] = mk(3, 9, 5, 40);
      push_msg(dmsg[0]);
      tick();
      push_msg(dmsg[1]);
      tick();
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (ctrl_en) seen = 1;
         tick();
      end
      check("gate_no_en", seen, 0);
      check("gate_count", count, 2);
      rx_turn = 1'b1;
      tick();
      check("gate_turn", turn_player, 1);
      check("gate_transmit", transmit, 1);
      wait_en("gate_en0", 10);
      check("gate_fields0", out_msg(), dmsg[0]);
      do_ack();
      wait_en("gate_en1", 10);
      check("gate_fields1", out_msg(), dmsg[1]);
      do_ack();

      // Overflow: nine pushes while not transmitting.
      rx_turn = 1'b1;
      tick();
      for (int i = 0; i < 9; i++) begin
         dmsg[i] = mk(i % 6, i + 4, i, 50 + i);
         push_msg(dmsg[i]);
         tick();
      end
      check("ovf_count", count, 8);
      check("ovf_full", full, 1);
      check("ovf_flag", overflow, 1);
      rx_turn = 1'b1;
      tick();
      rx_turn = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         wait_en($sformatf("ovf_en%0d", i), 20);
         check($sformatf("ovf_fields%0d", i), out_msg(), dmsg[i]);
         do_ack();
      end
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         if (ctrl_en) seen = 1;
         tick();
      end
      check("ovf_ninth_absent", seen, 0);
      check("ovf_empty", count, 0);

      // Sending STATE_TURN hands the turn on; STATE_RST_GAME goes out on any turn.
      m = mk(6, 1, 1, 1);
      push_msg(m);
      tick();
      wait_en("turnmsg_en", 10);
      check("turnmsg_fields", out_msg(), m);
      do_ack();
      check("turnmsg_turn", turn_player, 2);
      check("turnmsg_transmit", transmit, 0);
      m = mk(8, 2, 2, 2);
      push_msg(m);
      tick();
      wait_en("rstgame_en", 10);
      check("rstgame_fields", out_msg(), m);
      do_ack();
      check("rstgame_turn", turn_player, 0);
      rx_turn = 1'b1;
      tick();
      rx_turn = 1'b1;
      rx_rst_game = 1'b1;
      tick();
      check("rx_both_turn", turn_player, 0);

      // No acknowledge: one send plus three resends, 11 cycles apart, then error.
      rx_turn = 1'b1;
      tick();
      push_msg(mk(4, 5, 6, 7));
      np = 0;
      for (int c = 0; c < 80; c++) begin
         tick();
         if (ctrl_en) begin
            if (np < 8) times[np] = c;
            np++;
         end
      end
      check("retry_pulses", np, 4);
      for (int i = 0; i < 3; i++) begin
         if (i + 1 < np) check($sformatf("retry_gap%0d", i), times[i+1] - times[i], 11);
      end
      check("retry_error", error, 1);
      check("retry_busy", busy, 1);
      push_msg(mk(5, 1, 1, 1));
      tick();
      check("err_push_accepted", count, 1);
      interboard_rst = 1'b1;
      tick();
      check("irst_error", error, 0);
      check("irst_count", count, 0);
      check("irst_busy", busy, 0);
      check("irst_overflow", overflow, 0);
      check("irst_fields", out_msg(), 0);

      // Asynchronous reset in the middle of a handshake.
      rx_turn = 1'b1;
      tick();
      push_msg(mk(2, 11, 3, 9));
      tick();
      push_msg(mk(3, 12, 4, 10));
      tick();
      wait_en("arst_en", 4);
      check("arst_count_before", count, 1);
      tick();
      #2 rst = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_count", count, 0);
      check("arst_fields", out_msg(), 0);
      check("arst_turn", turn_player, 0);
      check("arst_ctrl_en", ctrl_en, 0);
      tick();
      rst = 1'b1;
      ctrl_ack = 1'b1;
      tick();
      check("arst_ack_ignored_busy", busy, 0);
      check("arst_ack_ignored_turn", turn_player, 0);
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         if (ctrl_en) seen = 1;
         tick();
      end
      check("arst_no_send", seen, 0);

      // Randomized traffic against a transaction-level model.
      turn_m = 0;
      prev_turn = 0;
      outstanding = 0;
      ack_in = 0;
      for (int c = 0; c < 2000; c++) begin
         tick();
         check("rnd_turn", turn_player, turn_m);
         check("rnd_transmit", transmit, turn_m == PLAYER);
         ack_now = 0;
         if (outstanding) begin
            ack_in--;
            if (ack_in == 0) begin
               ack_now = 1;
               outstanding = 0;
               ctrl_ack = 1'b1;
            end
         end
         if (ctrl_en) begin
            if (outstanding || ack_now) begin
               check("rnd_unexpected_resend", 1'b1, 1'b0);
            end else begin
               check("rnd_pending", q.size() != 0, 1);
               if (q.size() != 0) begin
                  check("rnd_fields", out_msg(), q[0]);
                  check("rnd_gating", (prev_turn == PLAYER) || (q[0].t == 4'd8), 1);
                  cur = q.pop_front();
                  outstanding = 1;
                  ack_in = $urandom_range(1, 5);
               end
            end
         end
         prev_turn = turn_m;
         if (c < 1200 && q.size() < 6 && $urandom_range(0, 2) == 0) begin
            m = rand_msg();
            push_msg(m);
            q.push_back(m);
         end
         rxt = ($urandom_range(0, 5) == 0);
         rxr = ($urandom_range(0, 39) == 0);
         rx_turn = rxt;
         rx_rst_game = rxr;
         if (rxr || (ack_now && cur.t == 4'd8)) turn_m = 0;
         else if (rxt || (ack_now && cur.t == 4'd6)) turn_m = (turn_m + 1) % NUM_PLAYERS;
         if (c >= 1200 && q.size() == 0 && !outstanding) break;
      end
      check("rnd_drained", q.size() + int'(outstanding), 0);
      tick();
      tick();
      check("rnd_end_count", count, 0);
      check("rnd_end_overflow", overflow, 0);
      check("rnd_end_error", error, 0);
      check("rnd_end_busy", busy, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
